// File: rtl/score_scheduler_if.sv
// Bundle of round control, award requests and score outputs between the
// game logic (master) and the score scheduler (slave).
interface score_scheduler_if #(
   parameter int unsigned SCORE_W = 16,
   parameter int unsigned PTS_W   = 4
);
   localparam int unsigned NUM_REQ = 4;

   logic                       start;
   logic                       stop;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*PTS_W-1:0]   points;
   logic [NUM_REQ-1:0]         ack;
   logic [SCORE_W-1:0]         score_out;
   logic [SCORE_W-1:0]         high_score;
   logic                       new_high;
   logic                       saturated;
   logic                       busy;

   modport master (
      output start, stop, req, points,
      input  ack, score_out, high_score, new_high, saturated, busy
   );

   modport slave (
      input  start, stop, req, points,
      output ack, score_out, high_score, new_high, saturated, busy
   );
endinterface

// File: rtl/score_scheduler.sv
// Round sequencer for the shared score register: round-robin award arbitration
// with saturating accumulation and high-score commit at the end of each round.
module score_scheduler #(
   parameter int unsigned SCORE_W = 16,
   parameter int unsigned PTS_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   score_scheduler_if.slave   bus
);
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned SUM_W   = SCORE_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_END  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SCORE_W-1:0]   high_q, high_d;
   logic                 new_high_q, new_high_d;
   logic                 sat_q, sat_d;
   logic                 busy_q, busy_d;
   logic [IDX_W-1:0]     last_q, last_d;

   logic [NUM_REQ-1:0]   elig;
   logic [PTS_W-1:0]     pts [NUM_REQ];
   logic [IDX_W-1:0]     cand;
   logic [IDX_W-1:0]     winner;
   logic                 found;
   logic [SUM_W-1:0]     sum;

   // Round-robin pick starting just after the last winner; the requester
   // being acknowledged this cycle is masked so it is not granted twice.
   always_comb begin
      elig   = bus.req & ~ack_q;
      found  = 1'b0;
      winner = last_q;
      cand   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pts[i] = bus.points[i*PTS_W +: PTS_W];
      end
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = last_q + IDX_W'(k);
         if (!found && elig[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      sum = {1'b0, score_q} + SUM_W'(pts[winner]);
   end

   // Next-state and registered-output values.
   always_comb begin
      state_d    = state_q;
      ack_d      = '0;
      score_d    = score_q;
      high_d     = high_q;
      new_high_d = 1'b0;
      sat_d      = sat_q;
      last_d     = last_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               score_d = '0;
               sat_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (found) begin
               ack_d  = NUM_REQ'(1) << winner;
               last_d = winner;
               if (sum[SCORE_W]) begin
                  score_d = '1;
                  sat_d   = 1'b1;
               end else begin
                  score_d = sum[SCORE_W-1:0];
               end
            end
            if (bus.stop) begin
               state_d = S_END;
            end
         end
         S_END: begin
            if (score_q > high_q) begin
               high_d     = score_q;
               new_high_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ack_q      <= '0;
         score_q    <= '0;
         high_q     <= '0;
         new_high_q <= 1'b0;
         sat_q      <= 1'b0;
         busy_q     <= 1'b0;
         last_q     <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         score_q    <= score_d;
         high_q     <= high_d;
         new_high_q <= new_high_d;
         sat_q      <= sat_d;
         busy_q     <= busy_d;
         last_q     <= last_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.score_out  = score_q;
   assign bus.high_score = high_q;
   assign bus.new_high   = new_high_q;
   assign bus.saturated  = sat_q;
   assign bus.busy       = busy_q;
endmodule
